sobel_stream: RTL and testbench
===============================

// Module: sobel_stream
// PURPOSE
//  Streaming, parametrised Sobel operator for the TOONIFY edge path.
//  Takes one 3x3 window per beat, computes |Gx|+|Gy| magnitude and a 4-way
//  quantised gradient direction. Adds a per-pixel edge flag against a
//  runtime threshold. Sits between the line-buffer window generator and
//  non-max suppression.
//  3-stage pipeline with valid/ready handshake on both sides. Full
//  throughput (1 window/cycle) when not back-pressured.
// PARAMETERS
//  DW    8  pixel / gradient-magnitude width; GW = DW+3 (local) signed Gx/Gy width
//  SHW   3  width of i_shift (magnitude right-shift amount)
// PORTS
//  i_clk      in   1      clock, all logic on rising edge
//  i_rst_n    in   1      synchronous active-low reset
//  i_valid    in   1      input window valid
//  o_ready    out  1      block can accept a window this cycle
//  i_pixel    in   9*DW   window p0..p8 row-major, p0 in MSBs [9*DW-1 -: DW]
//  i_shift    in   SHW    magnitude shift, captured with the beat
//  i_thresh   in   DW     edge threshold, captured with the beat
//  o_valid    out  1      output beat valid
//  i_ready    in   1      downstream accepts output
//  o_grad     out  DW     saturated magnitude
//  o_angle    out  2      0=horiz edge,1=diag(+),2=vert edge,3=diag(-)
//  o_edge     out  1      o_grad >= captured threshold
// BEHAVIOUR
//  Reset (i_rst_n==0 at posedge): all stage valids, o_valid, o_grad, o_angle,
//   o_edge -> 0. Reset mid-stream drops in-flight beats; no partial output.
//  Handshake: input transfer when i_valid&&o_ready; output when o_valid&&i_ready.
//   Stage k advances when it is empty or stage k+1 advances.
//   o_ready = !s1_valid || s1 advances (combinational from i_ready chain).
//   Outputs hold stable while o_valid&&!i_ready. Order preserved, no drops/dups.
//  Latency: 3 cycles from accepted input to o_valid with i_ready held high.
//  S1: Gx = (p0+2p1+p2)-(p6+2p7+p8); Gy = (p0+2p3+p6)-(p2+2p5+p8).
//   Both are GW-bit signed, exact (range +/-4*(2^DW-1)).
//   Register Gx, Gy, shift, thresh.
//  S2: ax=|Gx|, ay=|Gy| (GW-1 bits unsigned). sum=ax+ay (GW bits).
//   tx=(ax>>2)+(ax>>3)+(ax>>5)+(ax>>7); same for ty from ay (tan 22.5 deg approx).
//   cx = tx>ay; cy = ty>ax; sgn = Gx[GW-1]^Gy[GW-1].
//   Register sum, cx, cy, sgn, zero=(ax==0&&ay==0), thresh, shift.
//  S3: m = sum>>shift; o_grad = (m > 2^DW-1) ? 2^DW-1 : m.
//   o_angle = zero ? 0 : cx ? 0 : cy ? 2 : sgn ? 3 : 1.
//   o_edge = (o_grad >= thresh). Register to outputs.
//  Stall boundary: with i_ready low, at most 3 beats held; the 4th is refused
//   (o_ready=0). Accept and emit in the same cycle are allowed when full.
// TESTING (DW=8 unless stated)
//  1 All-zero window, shift=2, thresh=1 -> grad=0, angle=0, edge=0, 3 cycles later.
//  2 Top row 255, rest 0, shift=2 -> Gx=1020, grad=255, angle=0; left column 255 ->
//    grad=255, angle=2.
//  3 Only p0=255 -> grad=127, angle=1; only p2=255 -> grad=127, angle=3;
//    thresh=128 -> edge=0, thresh=127 -> edge=1.
//  4 Top row 255, shift=1 -> 510 saturates, grad=255; shift=4 -> grad=63.
//  5 Stream 6 windows, i_ready low cycles 2-7 -> o_ready drops after 3 held,
//    all 6 emerge in order, outputs stable while stalled.
//  6 Reset asserted with 2 beats in flight -> next cycle o_valid=0, no stale beats
//    after release; random windows vs reference model, 10k beats, full-rate and
//    random i_ready.

Source files
------------

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel: |Gx|+|Gy| magnitude, 4-way direction, edge flag.
// Three registered stages with valid/ready flow control on both sides.
module sobel_stream #(
  parameter int DW  = 8,
  parameter int SHW = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [9*DW-1:0] i_pixel,
  input  logic [SHW-1:0]  i_shift,
  input  logic [DW-1:0]   i_thresh,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [DW-1:0]   o_grad,
  output logic [1:0]      o_angle,
  output logic            o_edge
);

  localparam int GW = DW + 3;
  localparam int AW = GW - 1;

  typedef struct packed {
    logic [GW-1:0]  gx;
    logic [GW-1:0]  gy;
    logic [SHW-1:0] shift;
    logic [DW-1:0]  thresh;
  } s1_t;

  typedef struct packed {
    logic [GW-1:0]  sum;
    logic           cx;
    logic           cy;
    logic           sgn;
    logic           zero;
    logic [SHW-1:0] shift;
    logic [DW-1:0]  thresh;
  } s2_t;

  logic          s1_valid;
  logic          s2_valid;
  s1_t           s1_q;
  s1_t           s1_d;
  s2_t           s2_q;
  s2_t           s2_d;
  logic          s1_adv;
  logic          s2_adv;
  logic          s3_adv;

  logic [DW-1:0] p [9];
  logic [AW-1:0] ax;
  logic [AW-1:0] ay;
  logic [AW-1:0] tx;
  logic [AW-1:0] ty;
  logic [GW-1:0] m;
  logic [DW-1:0] grad_d;
  logic [1:0]    angle_d;
  logic          edge_d;

  assign s3_adv  = !o_valid || i_ready;
  assign s2_adv  = !s2_valid || s3_adv;
  assign s1_adv  = !s1_valid || s2_adv;
  assign o_ready = s1_adv;

  // Unpack the window, p0 taken from the most significant slice
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      p[k] = i_pixel[(9-k)*DW-1 -: DW];
    end
  end

  // Exact Gx/Gy in GW-bit two's complement
  always_comb begin
    s1_d        = '0;
    s1_d.gx     = (GW'(p[0]) + (GW'(p[1]) << 1) + GW'(p[2]))
                - (GW'(p[6]) + (GW'(p[7]) << 1) + GW'(p[8]));
    s1_d.gy     = (GW'(p[0]) + (GW'(p[3]) << 1) + GW'(p[6]))
                - (GW'(p[2]) + (GW'(p[5]) << 1) + GW'(p[8]));
    s1_d.shift  = i_shift;
    s1_d.thresh = i_thresh;
  end

  // Stage 1 register: gradients plus beat-captured controls
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= i_valid;
      if (i_valid) s1_q <= s1_d;
    end
  end

  // Magnitudes and tan(22.5) comparisons for direction binning
  always_comb begin
    ax = s1_q.gx[GW-1] ? AW'(-s1_q.gx) : AW'(s1_q.gx);
    ay = s1_q.gy[GW-1] ? AW'(-s1_q.gy) : AW'(s1_q.gy);
    tx = (ax >> 2) + (ax >> 3) + (ax >> 5) + (ax >> 7);
    ty = (ay >> 2) + (ay >> 3) + (ay >> 5) + (ay >> 7);
    s2_d        = '0;
    s2_d.sum    = GW'(ax) + GW'(ay);
    s2_d.cx     = tx > ay;
    s2_d.cy     = ty > ax;
    s2_d.sgn    = s1_q.gx[GW-1] ^ s1_q.gy[GW-1];
    s2_d.zero   = (ax == '0) && (ay == '0);
    s2_d.shift  = s1_q.shift;
    s2_d.thresh = s1_q.thresh;
  end

  // Stage 2 register: sum and direction flags
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= s2_d;
    end
  end

  // Shift, saturate, classify direction, compare threshold
  always_comb begin
    m       = s2_q.sum >> s2_q.shift;
    grad_d  = (|m[GW-1:DW]) ? '1 : m[DW-1:0];
    edge_d  = grad_d >= s2_q.thresh;
    if (s2_q.zero)     angle_d = 2'd0;
    else if (s2_q.cx)  angle_d = 2'd0;
    else if (s2_q.cy)  angle_d = 2'd2;
    else if (s2_q.sgn) angle_d = 2'd3;
    else               angle_d = 2'd1;
  end

  // Output register, held while downstream stalls
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_grad  <= '0;
      o_angle <= '0;
      o_edge  <= 1'b0;
    end else if (s3_adv) begin
      o_valid <= s2_valid;
      if (s2_valid) begin
        o_grad  <= grad_d;
        o_angle <= angle_d;
        o_edge  <= edge_d;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: directed spec cases, stall, reset, random stream.
// Expected beats come from an integer model of the Sobel rules.
module tb_sobel_stream;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [71:0] i_pixel;
  logic [2:0]  i_shift;
  logic [7:0]  i_thresh;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_grad;
  logic [1:0]  o_angle;
  logic        o_edge;

  typedef struct {
    logic [7:0] g;
    logic [1:0] a;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   total;
  int   bad;
  logic last_acc;
  logic hold_chk;
  logic blocked_seen;
  logic [7:0] hg;
  logic [1:0] ha;
  logic       he;

  sobel_stream #(.DW(8), .SHW(3)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_pixel  (i_pixel),
    .i_shift  (i_shift),
    .i_thresh (i_thresh),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_grad   (o_grad),
    .o_angle  (o_angle),
    .o_edge   (o_edge)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(input logic [71:0] w,
                                 input int sh, input int th);
    int p[9];
    int gx, gy, ax, ay, sum, mag, tx, ty;
    exp_t r;
    for (int k = 0; k < 9; k++) p[k] = int'(w[71-8*k -: 8]);
    gx  = p[0] + 2*p[1] + p[2] - p[6] - 2*p[7] - p[8];
    gy  = p[0] + 2*p[3] + p[6] - p[2] - 2*p[5] - p[8];
    ax  = gx < 0 ? -gx : gx;
    ay  = gy < 0 ? -gy : gy;
    sum = ax + ay;
    mag = sum / (1 << sh);
    if (mag > 255) mag = 255;
    tx  = ax/4 + ax/8 + ax/32 + ax/128;
    ty  = ay/4 + ay/8 + ay/32 + ay/128;
    r.g = 8'(mag);
    r.e = mag >= th;
    if (ax == 0 && ay == 0)       r.a = 2'd0;
    else if (tx > ay)             r.a = 2'd0;
    else if (ty > ax)             r.a = 2'd2;
    else if ((gx < 0) != (gy < 0)) r.a = 2'd3;
    else                          r.a = 2'd1;
    return r;
  endfunction

  function automatic logic [71:0] rand_win();
    logic [71:0] w;
    int mode;
    int v;
    mode = $urandom_range(0, 2);
    w = '0;
    for (int k = 0; k < 9; k++) begin
      if (mode == 0)      v = $urandom_range(0, 255);
      else if (mode == 1) v = $urandom_range(0, 1) ? 255 : 0;
      else                v = $urandom_range(0, 3);
      w[71-8*k -: 8] = 8'(v);
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge i_clk);
    if (hold_chk) begin
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_grad", 32'(o_grad), 32'(hg));
      check("hold_angle", 32'(o_angle), 32'(ha));
      check("hold_edge", 32'(o_edge), 32'(he));
    end
    hold_chk = o_valid && !i_ready;
    hg = o_grad;
    ha = o_angle;
    he = o_edge;
    if (!i_ready && q.size() == 3) begin
      check("full_block", 32'(o_ready), 32'd0);
      blocked_seen = 1'b1;
    end
    if (o_valid && i_ready) begin
      check("out_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_grad", 32'(o_grad), 32'(e.g));
        check("sb_angle", 32'(o_angle), 32'(e.a));
        check("sb_edge", 32'(o_edge), 32'(e.e));
      end
    end
    last_acc = i_valid && o_ready;
    if (last_acc)
      q.push_back(model(i_pixel, int'(i_shift), int'(i_thresh)));
    check("depth", 32'(q.size() <= 3), 32'd1);
    @(posedge i_clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [71:0] w,
                          input int sh, input int th, input int eg,
                          input int ea, input int ee);
    int lat;
    i_pixel  = w;
    i_shift  = 3'(sh);
    i_thresh = 8'(th);
    i_valid  = 1'b1;
    i_ready  = 1'b1;
    tick();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_grad"}, 32'(o_grad), 32'(eg));
    check({tag, "_angle"}, 32'(o_angle), 32'(ea));
    check({tag, "_edge"}, 32'(o_edge), 32'(ee));
  endtask

  initial begin
    int sent;
    total        = 0;
    bad          = 0;
    hold_chk     = 1'b0;
    blocked_seen = 1'b0;
    last_acc     = 1'b0;
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_pixel  = '0;
    i_shift  = '0;
    i_thresh = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_grad", 32'(o_grad), 32'd0);
    check("rst_angle", 32'(o_angle), 32'd0);
    check("rst_edge", 32'(o_edge), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    i_rst_n = 1'b1;

    directed("zero", 72'h0, 2, 1, 0, 0, 0);
    directed("toprow", {8'hff, 8'hff, 8'hff, 48'h0}, 2, 0, 255, 0, 1);
    directed("leftcol", {8'hff, 16'h0, 8'hff, 16'h0, 8'hff, 16'h0},
             2, 0, 255, 2, 1);
    directed("p0_th128", {8'hff, 64'h0}, 2, 128, 127, 1, 0);
    directed("p0_th127", {8'hff, 64'h0}, 2, 127, 127, 1, 1);
    directed("p2", {16'h0, 8'hff, 48'h0}, 2, 0, 127, 3, 1);
    directed("sat_sh1", {8'hff, 8'hff, 8'hff, 48'h0}, 1, 0, 255, 0, 1);
    directed("sh4", {8'hff, 8'hff, 8'hff, 48'h0}, 4, 64, 63, 0, 0);
    repeat (3) tick();

    sent = 0;
    i_pixel  = rand_win();
    i_shift  = 3'($urandom_range(0, 7));
    i_thresh = 8'($urandom_range(0, 255));
    for (int c = 0; c < 40 && (sent < 6 || q.size() > 0); c++) begin
      i_ready = !(c >= 2 && c <= 7);
      i_valid = sent < 6;
      tick();
      if (last_acc) begin
        sent++;
        i_pixel  = rand_win();
        i_shift  = 3'($urandom_range(0, 7));
        i_thresh = 8'($urandom_range(0, 255));
      end
    end
    check("stall_sent", 32'(sent), 32'd6);
    check("stall_drain", 32'(q.size()), 32'd0);
    check("stall_blocked", 32'(blocked_seen), 32'd1);

    i_ready = 1'b1;
    i_valid = 1'b1;
    repeat (2) begin
      i_pixel = rand_win();
      tick();
    end
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_grad", 32'(o_grad), 32'd0);
    check("mid_rst_edge", 32'(o_edge), 32'd0);
    q.delete();
    hold_chk = 1'b0;
    i_rst_n  = 1'b1;
    repeat (8) tick();

    i_valid = 1'b1;
    i_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      i_pixel  = rand_win();
      i_shift  = 3'($urandom_range(0, 7));
      i_thresh = 8'($urandom_range(0, 255));
      tick();
      check("fullrate_acc", 32'(last_acc), 32'd1);
    end

    i_valid = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      i_ready = $urandom_range(0, 3) != 0;
      if (last_acc || !i_valid) begin
        i_pixel  = rand_win();
        i_shift  = 3'($urandom_range(0, 7));
        i_thresh = 8'($urandom_range(0, 255));
        i_valid  = $urandom_range(0, 3) != 0;
      end
      tick();
    end

    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() > 0; n++) tick();
    check("final_drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
